// File: rtl/psx_pad_scheduler.sv
// psx_pad_scheduler: round-robin poller for two PSX pads on a shared clk/cmd/data/ack bus.
// Latency: one 5-byte poll per POLL_INTERVAL; btnN/pad_valid update one cycle after CHECK.
// Backpressure: none; a poll request raised while a transaction is in flight is dropped.
module psx_pad_scheduler #(
   parameter int CLK_DIV       = 4,
   parameter int ATT_SETUP     = 8,
   parameter int ACK_TIMEOUT   = 64,
   parameter int POLL_INTERVAL = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        data,
   input  logic        ack,
   output logic        psx_clk,
   output logic        cmd,
   output logic [1:0]  att,
   output logic        busy,
   output logic [15:0] btn0,
   output logic [15:0] btn1,
   output logic [1:0]  pad_valid,
   output logic [1:0]  pad_present,
   output logic [1:0]  timeout_err
);

   // One shared counter serves the att setup, att hold and ack timeout windows.
   localparam int CMAX = (ACK_TIMEOUT > ATT_SETUP) ? ACK_TIMEOUT : ATT_SETUP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = $clog2(2 * CLK_DIV);
   localparam int IW   = $clog2(POLL_INTERVAL);

   localparam logic [CW-1:0] SETUP_LAST = CW'(ATT_SETUP - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(ACK_TIMEOUT - 1);
   localparam logic [PW-1:0] PH_LOW_END = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);
   localparam logic [IW-1:0] IV_LAST    = IW'(POLL_INTERVAL - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_ACKW,
      S_CHECK,
      S_FAIL,
      S_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    data_sync_q, data_sync_d;
   logic [1:0]    ack_sync_q, ack_sync_d;
   logic [IW-1:0] iv_cnt_q, iv_cnt_d;
   logic          port_q, port_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [2:0]    bit_q, bit_d;
   logic [2:0]    idx_q, idx_d;
   logic [6:0]    rx_q, rx_d;
   logic [3:0]    rx_id_q, rx_id_d;
   logic [7:0]    rx_hdr_q, rx_hdr_d;
   logic [7:0]    rx_lo_q, rx_lo_d;
   logic [7:0]    rx_hi_q, rx_hi_d;
   logic          psx_clk_q, psx_clk_d;
   logic          cmd_q, cmd_d;
   logic [1:0]    att_q, att_d;
   logic          busy_q, busy_d;
   logic [15:0]   btn0_q, btn0_d;
   logic [15:0]   btn1_q, btn1_d;
   logic [1:0]    pad_valid_q, pad_valid_d;
   logic [1:0]    pad_present_q, pad_present_d;
   logic [1:0]    timeout_err_q, timeout_err_d;

   logic          data_s;
   logic          ack_s;
   logic          poll_req;
   logic [7:0]    rx_byte;
   logic [2:0]    idx_nxt;
   logic [2:0]    bit_nxt;
   logic          hdr_ok;

   // Poll command bytes: 01 42 00 00 00, sent LSB first.
   function automatic logic tx_bit(input logic [2:0] idx, input logic [2:0] b);
      logic [7:0] v;
      case (idx)
         3'd0:    v = 8'h01;
         3'd1:    v = 8'h42;
         default: v = 8'h00;
      endcase
      return v[b];
   endfunction

   assign data_s = data_sync_q[1];
   assign ack_s  = ack_sync_q[1];

   // Input synchronizers and the free-running poll interval timer.
   always_comb begin
      data_sync_d = {data_sync_q[0], data};
      ack_sync_d  = {ack_sync_q[0], ack};
      iv_cnt_d    = iv_cnt_q;
      poll_req    = 1'b0;
      if (!enable) begin
         iv_cnt_d = '0;
      end else if (iv_cnt_q == IV_LAST) begin
         iv_cnt_d = '0;
         poll_req = 1'b1;
      end else begin
         iv_cnt_d = iv_cnt_q + 1'b1;
      end
   end

   // Transaction sequencer; every pin-level output is computed here and registered.
   always_comb begin
      state_d       = state_q;
      port_d        = port_q;
      cnt_d         = cnt_q;
      ph_d          = ph_q;
      bit_d         = bit_q;
      idx_d         = idx_q;
      rx_d          = rx_q;
      rx_id_d       = rx_id_q;
      rx_hdr_d      = rx_hdr_q;
      rx_lo_d       = rx_lo_q;
      rx_hi_d       = rx_hi_q;
      psx_clk_d     = psx_clk_q;
      cmd_d         = cmd_q;
      att_d         = att_q;
      busy_d        = busy_q;
      btn0_d        = btn0_q;
      btn1_d        = btn1_q;
      pad_valid_d   = 2'b00;
      pad_present_d = pad_present_q;
      timeout_err_d = 2'b00;
      rx_byte       = {data_s, rx_q};
      idx_nxt       = idx_q + 3'd1;
      bit_nxt       = bit_q + 3'd1;
      hdr_ok        = ((rx_id_q == 4'h4) || (rx_id_q == 4'h7)) && (rx_hdr_q == 8'h5A);

      case (state_q)
         S_IDLE: begin
            psx_clk_d = 1'b1;
            cmd_d     = 1'b1;
            att_d     = 2'b11;
            if (poll_req) begin
               state_d = S_SETUP;
               busy_d  = 1'b1;
               cnt_d   = '0;
               // Only the polled port's att is ever pulled low.
               att_d   = port_q ? 2'b01 : 2'b10;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d   = S_SHIFT;
               idx_d     = 3'd0;
               bit_d     = 3'd0;
               ph_d      = '0;
               psx_clk_d = 1'b0;
               cmd_d     = tx_bit(3'd0, 3'd0);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_SHIFT: begin
            if (ph_q == PH_LAST) begin
               // End of the high phase: take the synced data bit.
               rx_d = {data_s, rx_q[6:1]};
               ph_d = '0;
               if (bit_q == 3'd7) begin
                  case (idx_q)
                     3'd1:    rx_id_d  = rx_byte[7:4];
                     3'd2:    rx_hdr_d = rx_byte;
                     3'd3:    rx_lo_d  = rx_byte;
                     3'd4:    rx_hi_d  = rx_byte;
                     default: ;
                  endcase
                  cmd_d     = 1'b1;
                  psx_clk_d = 1'b1;
                  if (idx_q == 3'd4) begin
                     state_d = S_CHECK;
                  end else begin
                     state_d = S_ACKW;
                     cnt_d   = '0;
                  end
               end else begin
                  bit_d     = bit_nxt;
                  psx_clk_d = 1'b0;
                  cmd_d     = tx_bit(idx_q, bit_nxt);
               end
            end else begin
               ph_d = ph_q + 1'b1;
               if (ph_q == PH_LOW_END) begin
                  psx_clk_d = 1'b1;
               end
            end
         end

         S_ACKW: begin
            psx_clk_d = 1'b1;
            // An ack already low on entry is accepted on the first cycle.
            if (!ack_s) begin
               state_d   = S_SHIFT;
               idx_d     = idx_nxt;
               bit_d     = 3'd0;
               ph_d      = '0;
               psx_clk_d = 1'b0;
               cmd_d     = tx_bit(idx_nxt, 3'd0);
            end else if (cnt_q == TO_LAST) begin
               state_d = S_FAIL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_CHECK: begin
            if (hdr_ok) begin
               if (port_q) begin
                  btn1_d = ~{rx_hi_q, rx_lo_q};
               end else begin
                  btn0_d = ~{rx_hi_q, rx_lo_q};
               end
               pad_valid_d[port_q]   = 1'b1;
               pad_present_d[port_q] = 1'b1;
               state_d               = S_HOLD;
               cnt_d                 = '0;
               att_d                 = 2'b11;
               psx_clk_d             = 1'b1;
               cmd_d                 = 1'b1;
            end else begin
               state_d = S_FAIL;
            end
         end

         S_FAIL: begin
            // Buttons keep their last good value; only presence drops.
            pad_present_d[port_q] = 1'b0;
            timeout_err_d[port_q] = 1'b1;
            state_d               = S_HOLD;
            cnt_d                 = '0;
            att_d                 = 2'b11;
            psx_clk_d             = 1'b1;
            cmd_d                 = 1'b1;
         end

         S_HOLD: begin
            att_d     = 2'b11;
            psx_clk_d = 1'b1;
            cmd_d     = 1'b1;
            if (cnt_q == SETUP_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               port_d  = ~port_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction without touching btnN mid-way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         data_sync_q   <= 2'b11;
         ack_sync_q    <= 2'b11;
         iv_cnt_q      <= '0;
         port_q        <= 1'b0;
         cnt_q         <= '0;
         ph_q          <= '0;
         bit_q         <= 3'd0;
         idx_q         <= 3'd0;
         rx_q          <= 7'd0;
         rx_id_q       <= 4'd0;
         rx_hdr_q      <= 8'd0;
         rx_lo_q       <= 8'd0;
         rx_hi_q       <= 8'd0;
         psx_clk_q     <= 1'b1;
         cmd_q         <= 1'b1;
         att_q         <= 2'b11;
         busy_q        <= 1'b0;
         btn0_q        <= 16'd0;
         btn1_q        <= 16'd0;
         pad_valid_q   <= 2'b00;
         pad_present_q <= 2'b00;
         timeout_err_q <= 2'b00;
      end else begin
         state_q       <= state_d;
         data_sync_q   <= data_sync_d;
         ack_sync_q    <= ack_sync_d;
         iv_cnt_q      <= iv_cnt_d;
         port_q        <= port_d;
         cnt_q         <= cnt_d;
         ph_q          <= ph_d;
         bit_q         <= bit_d;
         idx_q         <= idx_d;
         rx_q          <= rx_d;
         rx_id_q       <= rx_id_d;
         rx_hdr_q      <= rx_hdr_d;
         rx_lo_q       <= rx_lo_d;
         rx_hi_q       <= rx_hi_d;
         psx_clk_q     <= psx_clk_d;
         cmd_q         <= cmd_d;
         att_q         <= att_d;
         busy_q        <= busy_d;
         btn0_q        <= btn0_d;
         btn1_q        <= btn1_d;
         pad_valid_q   <= pad_valid_d;
         pad_present_q <= pad_present_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign psx_clk     = psx_clk_q;
   assign cmd         = cmd_q;
   assign att         = att_q;
   assign busy        = busy_q;
   assign btn0        = btn0_q;
   assign btn1        = btn1_q;
   assign pad_valid   = pad_valid_q;
   assign pad_present = pad_present_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_psx_pad_scheduler.sv
// tb_psx_pad_scheduler: directed poll scenarios against a behavioural two-port pad model.
// Each table row is one poll; the bench checks pins, timing, buttons and status flags.
// Reset-abort and enable-drop sequences are hand-written after the table.
module tb_psx_pad_scheduler;
   localparam int CLK_DIV     = 4;
   localparam int ATT_SETUP   = 8;
   localparam int ACK_TIMEOUT = 64;
   localparam int PI          = 1024;
   localparam int NV          = 7;
   localparam logic [39:0] CMD_EXP = 40'h00_0000_4201;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        enable = 1'b0;
   logic        data   = 1'b1;
   logic        ack    = 1'b1;
   logic        psx_clk;
   logic        cmd;
   logic [1:0]  att;
   logic        busy;
   logic [15:0] btn0;
   logic [15:0] btn1;
   logic [1:0]  pad_valid;
   logic [1:0]  pad_present;
   logic [1:0]  timeout_err;

   psx_pad_scheduler #(
      .CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
      .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_INTERVAL(PI)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .data(data), .ack(ack),
      .psx_clk(psx_clk), .cmd(cmd), .att(att), .busy(busy),
      .btn0(btn0), .btn1(btn1), .pad_valid(pad_valid),
      .pad_present(pad_present), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // port, present, response {b4,b3,b2,b1,b0}, ok, expected btn0, btn1, pad_present
   typedef struct packed {
      logic        port;
      logic        present;
      logic [39:0] r;
      logic        ok;
      logic [15:0] e_btn0;
      logic [15:0] e_btn1;
      logic [1:0]  e_pres;
   } vec_t;

   vec_t vec [NV];

   int total = 0;
   int bad   = 0;

   // pad model / monitor state
   int          cyc = 0;
   int          att_fall_cyc = 0, att_rise_cyc = 0, busy_fall_cyc = 0;
   int          first_fall_cyc = 0, last_rise_cyc = 0, te_cyc = 0;
   int          bit_cnt = 0, byte_i = 0, bit_i = 0, ack_cd = 0, ack_low = 0;
   int          both_low = 0, att_act = 0;
   int          pv_cnt [2];
   int          te_cnt [2];
   bit          first_fall_seen = 1'b0, te_seen = 1'b0;
   bit          pres [2];
   logic [39:0] resp [2];
   logic [39:0] cap = '0;
   logic        prev_clk = 1'b1, prev_busy = 1'b0;
   logic [1:0]  prev_att = 2'b11;
   int          sel = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_att(input int lim, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < lim; k++) begin
         @(negedge clk); #1;
         if (att != 2'b11) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < lim; k++) begin
         @(negedge clk); #1;
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic clr_pulses();
      pv_cnt[0] = 0; pv_cnt[1] = 0;
      te_cnt[0] = 0; te_cnt[1] = 0;
   endtask

   // Pad model and monitor: pad shifts data on psx_clk fall, acks 10 cycles after bytes 0..3.
   initial begin
      clr_pulses();
      forever begin
         @(negedge clk);
         cyc++;
         if (att == 2'b00) both_low++;
         if (att != 2'b11) att_act++;
         if (pad_valid[0]) pv_cnt[0]++;
         if (pad_valid[1]) pv_cnt[1]++;
         if (timeout_err[0]) te_cnt[0]++;
         if (timeout_err[1]) te_cnt[1]++;
         if (prev_att == 2'b11 && att != 2'b11) begin
            att_fall_cyc = cyc; first_fall_seen = 1'b0; te_seen = 1'b0;
            bit_cnt = 0; byte_i = 0; bit_i = 0; cap = '0;
         end
         if (prev_att != 2'b11 && att == 2'b11) att_rise_cyc = cyc;
         if (prev_busy && !busy) busy_fall_cyc = cyc;
         if (timeout_err != 2'b00 && !te_seen) begin te_seen = 1'b1; te_cyc = cyc; end
         sel = (att == 2'b01) ? 1 : 0;
         if (att == 2'b11) begin
            data = 1'b1; ack = 1'b1; ack_cd = 0; ack_low = 0;
         end else begin
            if (prev_clk && !psx_clk) begin
               if (!first_fall_seen) begin first_fall_seen = 1'b1; first_fall_cyc = cyc; end
               if (pres[sel] && byte_i < 5) data = resp[sel][byte_i*8 + bit_i];
               else data = 1'b1;
            end
            if (!prev_clk && psx_clk) begin
               last_rise_cyc = cyc;
               if (bit_cnt < 40) cap[bit_cnt] = cmd;
               bit_cnt++;
               bit_i++;
               if (bit_i == 8) begin
                  bit_i = 0;
                  if (pres[sel] && byte_i < 4) ack_cd = 10;
                  byte_i++;
               end
            end
            if (ack_low > 0) begin ack_low--; if (ack_low == 0) ack = 1'b1; end
            if (ack_cd > 0) begin ack_cd--; if (ack_cd == 0) begin ack = 1'b0; ack_low = 3; end end
         end
         prev_clk  = psx_clk;
         prev_att  = att;
         prev_busy = busy;
      end
   end

   initial begin
      bit ok;
      int prev_fall;
      int exp_bits;
      logic [39:0] mask;

      vec[0] = {1'b0, 1'b1, 40'h7F_FE_5A_41_FF, 1'b1, 16'h8001, 16'h0000, 2'b01};
      vec[1] = {1'b1, 1'b1, 40'hFF_00_5A_73_FF, 1'b1, 16'h8001, 16'h00FF, 2'b11};
      vec[2] = {1'b0, 1'b1, 40'hA5_5A_5A_41_FF, 1'b1, 16'h5AA5, 16'h00FF, 2'b11};
      vec[3] = {1'b1, 1'b0, 40'hFF_FF_FF_FF_FF, 1'b0, 16'h5AA5, 16'h00FF, 2'b01};
      vec[4] = {1'b0, 1'b1, 40'h34_12_00_41_FF, 1'b0, 16'h5AA5, 16'h00FF, 2'b00};
      vec[5] = {1'b1, 1'b1, 40'h12_34_5A_41_FF, 1'b1, 16'h5AA5, 16'hEDCB, 2'b10};
      vec[6] = {1'b0, 1'b1, 40'h00_00_5A_51_FF, 1'b0, 16'h5AA5, 16'hEDCB, 2'b10};
      pres[0] = 1'b0; pres[1] = 1'b0;
      resp[0] = '1;   resp[1] = '1;

      // reset state
      repeat (3) @(negedge clk); #1;
      chk("rst_pins", {psx_clk, cmd, att}, 4'b1111);
      chk("rst_busy", busy, 0);
      chk("rst_btn", {btn0, btn1}, 0);
      chk("rst_flags", {pad_valid, pad_present, timeout_err}, 0);
      rst = 1'b0;
      enable = 1'b1;
      prev_fall = 0;

      for (int i = 0; i < NV; i++) begin
         pres[vec[i].port] = vec[i].present;
         resp[vec[i].port] = vec[i].r;
         clr_pulses();
         wait_att(2 * PI, ok);
         chk($sformatf("v%0d_att_fall", i), ok, 1);
         chk($sformatf("v%0d_att", i), att, vec[i].port ? 2'b01 : 2'b10);
         if (i > 0) chk($sformatf("v%0d_interval", i), att_fall_cyc - prev_fall, PI);
         prev_fall = att_fall_cyc;
         wait_idle(1200, ok);
         chk($sformatf("v%0d_done", i), ok, 1);
         repeat (2) @(negedge clk); #1;
         chk($sformatf("v%0d_setup", i), first_fall_cyc - att_fall_cyc, ATT_SETUP);
         chk($sformatf("v%0d_hold", i), busy_fall_cyc - att_rise_cyc, ATT_SETUP);
         exp_bits = vec[i].present ? 40 : 8;
         mask = (exp_bits == 40) ? '1 : 40'hFF;
         chk($sformatf("v%0d_bits", i), bit_cnt, exp_bits);
         chk($sformatf("v%0d_cmd", i), cap & mask, CMD_EXP & mask);
         chk($sformatf("v%0d_pv0", i), pv_cnt[0], (vec[i].ok && !vec[i].port) ? 1 : 0);
         chk($sformatf("v%0d_pv1", i), pv_cnt[1], (vec[i].ok && vec[i].port) ? 1 : 0);
         chk($sformatf("v%0d_te0", i), te_cnt[0], (!vec[i].ok && !vec[i].port) ? 1 : 0);
         chk($sformatf("v%0d_te1", i), te_cnt[1], (!vec[i].ok && vec[i].port) ? 1 : 0);
         chk($sformatf("v%0d_btn0", i), btn0, vec[i].e_btn0);
         chk($sformatf("v%0d_btn1", i), btn1, vec[i].e_btn1);
         chk($sformatf("v%0d_present", i), pad_present, vec[i].e_pres);
         if (!vec[i].present)
            chk($sformatf("v%0d_to_window", i),
                (te_cyc - last_rise_cyc >= ACK_TIMEOUT) && (te_cyc - last_rise_cyc <= ACK_TIMEOUT + 8), 1);
      end

      // enable dropped mid-transaction: poll completes, then the bus stays quiet
      pres[0] = 1'b1; resp[0] = vec[0].r;
      pres[1] = 1'b1; resp[1] = 40'h11_22_5A_41_FF;
      clr_pulses();
      wait_att(2 * PI, ok);
      chk("en_att_fall", ok, 1);
      chk("en_att", att, 2'b01);
      repeat (100) @(negedge clk); #1;
      enable = 1'b0;
      wait_idle(1200, ok);
      chk("en_done", ok, 1);
      repeat (2) @(negedge clk); #1;
      chk("en_bits", bit_cnt, 40);
      chk("en_pv1", pv_cnt[1], 1);
      chk("en_btn1", btn1, 16'hEEDD);
      att_act = 0;
      repeat (3 * PI) @(negedge clk); #1;
      chk("en_quiet", att_act, 0);
      chk("en_busy", busy, 0);

      // reset asserted during byte 2 aborts at once
      enable = 1'b1;
      wait_att(2 * PI, ok);
      chk("rs_att_fall", ok, 1);
      chk("rs_att", att, 2'b10);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (bit_cnt >= 20) begin ok = 1'b1; break; end
      end
      chk("rs_byte2", ok, 1);
      #2 rst = 1'b1;
      #1;
      chk("rs_pins", {psx_clk, cmd, att}, 4'b1111);
      chk("rs_busy", busy, 0);
      chk("rs_btn", {btn0, btn1}, 0);
      chk("rs_flags", {pad_valid, pad_present, timeout_err}, 0);
      enable = 1'b0;
      repeat (3) @(negedge clk); #1;
      rst = 1'b0;
      repeat (50) @(negedge clk); #1;
      chk("rs_after_att", att, 2'b11);
      chk("rs_after_btn", {btn0, btn1}, 0);

      chk("att_never_both", both_low, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
